// File: rtl/de_morgan_checker_if.sv
// Bus between the De Morgan checker, its controller and the external DUT.
// Carries start/mode in, stimulus vec out, dut_y back, and the result status.
interface de_morgan_checker_if #(
    parameter int WIDTH = 2
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] vec;
    logic             dut_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH:0]   err_cnt;
    logic [WIDTH-1:0] first_fail;

    modport master (
        input  start, mode, dut_y,
        output vec, busy, done, pass, err_cnt, first_fail
    );

    modport slave (
        output start, mode, dut_y,
        input  vec, busy, done, pass, err_cnt, first_fail
    );
endinterface

// File: rtl/de_morgan_checker.sv
// Exhaustive clocked stimulus/compare engine for an N-input De Morgan DUT.
// Ports: clk, rst_n (sync, active-low), bus (master: start, mode, dut_y in;
// vec, busy, done, pass, err_cnt, first_fail out).
// Optional: define DE_MORGAN_CHECKER_STOP_ON_FAIL_EN to stop at first mismatch.
module de_morgan_checker #(
    parameter int WIDTH       = 2,
    parameter int HOLD_CYCLES = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    de_morgan_checker_if.master bus
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] vec_q, vec_n;
    logic [HW-1:0]    hold_q, hold_n;
    logic [WIDTH:0]   err_q, err_n;
    logic [WIDTH-1:0] ff_q, ff_n;
    logic             pass_q, pass_n;
    logic             mode_q, mode_n;
    logic             golden;
    logic             mismatch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            vec_q  <= '0;
            hold_q <= '0;
            err_q  <= '0;
            ff_q   <= '0;
            pass_q <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            state  <= state_n;
            vec_q  <= vec_n;
            hold_q <= hold_n;
            err_q  <= err_n;
            ff_q   <= ff_n;
            pass_q <= pass_n;
            mode_q <= mode_n;
        end
    end

    always_comb begin
        state_n  = state;
        vec_n    = vec_q;
        hold_n   = hold_q;
        err_n    = err_q;
        ff_n     = ff_q;
        pass_n   = pass_q;
        mode_n   = mode_q;
        golden   = mode_q ? ~(|vec_q) : ~(&vec_q);
        mismatch = (bus.dut_y != golden);

        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n = RUN;
                    vec_n   = '0;
                    hold_n  = '0;
                    err_n   = '0;
                    ff_n    = '0;
                    pass_n  = 1'b0;
                    mode_n  = bus.mode;
                end
            end
            RUN: begin
                if (hold_q != HOLD_LAST) begin
                    hold_n = hold_q + 1'b1;
                end else begin
                    hold_n = '0;
                    if (mismatch) begin
                        err_n = err_q + {{WIDTH{1'b0}}, 1'b1};
                        if (err_q == '0)
                            ff_n = vec_q;
                    end
`ifdef DE_MORGAN_CHECKER_STOP_ON_FAIL_EN
                    // vec stays on the failing vector for inspection
                    if (mismatch || vec_q == ALL_ONES) begin
`else
                    if (vec_q == ALL_ONES) begin
`endif
                        state_n = DONE;
                        pass_n  = (err_n == '0);
                    end else begin
                        vec_n = vec_q + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.vec        = vec_q;
    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_q;
    assign bus.first_fail = ff_q;
endmodule
